// File: rtl/mbldcm_pkg.sv
// Shared constants and state encoding for the BLDC speed-ramp sequencer.
// Also used by the Avalon-MM register interface.
package mbldcm_pkg;

   localparam int unsigned FREQ_WIDTH_DEF     = 32;
   localparam int unsigned STEP_WIDTH_DEF     = 16;
   localparam int unsigned DWELL_WIDTH_DEF    = 24;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 1000000;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CALC      = 3'd1,
      ST_LATCH     = 3'd2,
      ST_WAIT_REFL = 3'd3,
      ST_DWELL     = 3'd4,
      ST_DONE      = 3'd5
   } ramp_state_e;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mbldcm_ramp_step.sv
// Next frequency-target value: one step toward the goal, saturating at the goal.
// A zero step means a single jump straight to the goal.
module mbldcm_ramp_step
   import mbldcm_pkg::*;
#(
   parameter int unsigned FREQ_WIDTH = FREQ_WIDTH_DEF,
   parameter int unsigned STEP_WIDTH = STEP_WIDTH_DEF
) (
   input  logic [FREQ_WIDTH-1:0] cur,
   input  logic [FREQ_WIDTH-1:0] goal,
   input  logic [STEP_WIDTH-1:0] step,
   output logic [FREQ_WIDTH-1:0] next_freq_c,
   output logic                  at_goal_c
);

   logic [FREQ_WIDTH-1:0] step_ext;
   logic [FREQ_WIDTH-1:0] diff;
   logic                  up;

   // Distance is taken in the direction of travel so neither subtraction can wrap.
   always_comb begin
      step_ext  = FREQ_WIDTH'(step);
      up        = (cur < goal);
      diff      = up ? (goal - cur) : (cur - goal);
      at_goal_c = (cur == goal);
      if (at_goal_c || (step == '0) || (diff <= step_ext)) begin
         next_freq_c = goal;
      end else if (up) begin
         next_freq_c = cur + step_ext;
      end else begin
         next_freq_c = cur - step_ext;
      end
   end

endmodule

// File: rtl/mbldcm_ramp_ctrl.sv
// Speed-ramp sequencer: steps the core frequency target toward a goal, one latch
// strobe per step, waiting for reflection and then dwelling before the next step.
module mbldcm_ramp_ctrl
   import mbldcm_pkg::*;
#(
   parameter int unsigned FREQ_WIDTH     = FREQ_WIDTH_DEF,
   parameter int unsigned STEP_WIDTH     = STEP_WIDTH_DEF,
   parameter int unsigned DWELL_WIDTH    = DWELL_WIDTH_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic [FREQ_WIDTH-1:0]  goal_freq,
   input  logic [STEP_WIDTH-1:0]  step,
   input  logic [DWELL_WIDTH-1:0] dwell,
   input  logic                   freq_reflected,
   output logic [FREQ_WIDTH-1:0]  freq_target,
   output logic                   latch_freq_target,
   output logic                   enable,
   output logic                   busy,
   output logic                   done,
   output logic                   error
);

   localparam int unsigned          TMO_WIDTH = cnt_width(TIMEOUT_CYCLES);
   localparam logic [TMO_WIDTH-1:0] TMO_LAST  = TMO_WIDTH'(TIMEOUT_CYCLES - 1);

   ramp_state_e            state, state_n;
   logic [FREQ_WIDTH-1:0]  goal_q, freq_n, next_freq;
   logic [STEP_WIDTH-1:0]  step_q;
   logic [DWELL_WIDTH-1:0] dwell_q, dwell_cnt, dwell_cnt_n, dwell_last;
   logic [TMO_WIDTH-1:0]   tmo_cnt, tmo_cnt_n;
   logic                   enable_n, error_n, capture_c, at_goal;

   mbldcm_ramp_step #(
      .FREQ_WIDTH (FREQ_WIDTH),
      .STEP_WIDTH (STEP_WIDTH)
   ) u_step (
      .cur         (freq_target),
      .goal        (goal_q),
      .step        (step_q),
      .next_freq_c (next_freq),
      .at_goal_c   (at_goal)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_n     = state;
      freq_n      = freq_target;
      enable_n    = enable;
      error_n     = error;
      dwell_cnt_n = dwell_cnt;
      tmo_cnt_n   = tmo_cnt;
      capture_c   = 1'b0;
      dwell_last  = (dwell_q == '0) ? '0 : (dwell_q - DWELL_WIDTH'(1));

      unique case (state)
         ST_IDLE: begin
            if (start && !abort) begin
               capture_c = 1'b1;
               error_n   = 1'b0;
               if (goal_freq != '0) enable_n = 1'b1;
               state_n   = ST_CALC;
            end
         end
         ST_CALC: begin
            if (at_goal) begin
               state_n = ST_DONE;
            end else begin
               freq_n  = next_freq;
               state_n = ST_LATCH;
            end
         end
         ST_LATCH: begin
            tmo_cnt_n = '0;
            state_n   = ST_WAIT_REFL;
         end
         ST_WAIT_REFL: begin
            if (freq_reflected) begin
               dwell_cnt_n = '0;
               state_n     = ST_DWELL;
            end else if (tmo_cnt == TMO_LAST) begin
               error_n = 1'b1;
               state_n = ST_IDLE;
            end else begin
               tmo_cnt_n = tmo_cnt + TMO_WIDTH'(1);
            end
         end
         ST_DWELL: begin
            if (dwell_cnt >= dwell_last) begin
               state_n = (freq_target == goal_q) ? ST_DONE : ST_CALC;
            end else begin
               dwell_cnt_n = dwell_cnt + DWELL_WIDTH'(1);
            end
         end
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase

      // Abort freezes target and enable where they are.
      if (abort && (state != ST_IDLE)) begin
         state_n  = ST_IDLE;
         freq_n   = freq_target;
         enable_n = enable;
         error_n  = error;
      end

      if ((state_n == ST_DONE) && (goal_q == '0)) enable_n = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= ST_IDLE;
         goal_q            <= '0;
         step_q            <= '0;
         dwell_q           <= '0;
         dwell_cnt         <= '0;
         tmo_cnt           <= '0;
         freq_target       <= '0;
         latch_freq_target <= 1'b0;
         enable            <= 1'b0;
         busy              <= 1'b0;
         done              <= 1'b0;
         error             <= 1'b0;
      end else begin
         state             <= state_n;
         dwell_cnt         <= dwell_cnt_n;
         tmo_cnt           <= tmo_cnt_n;
         freq_target       <= freq_n;
         latch_freq_target <= (state_n == ST_LATCH);
         enable            <= enable_n;
         busy              <= (state_n != ST_IDLE);
         done              <= (state_n == ST_DONE);
         error             <= error_n;
         if (capture_c) begin
            goal_q  <= goal_freq;
            step_q  <= step;
            dwell_q <= dwell;
         end
      end
   end

endmodule
